// File: rtl/mux_8x1_pkg.sv
// mux_8x1 shared definitions: select codes and default data width.
// Imported by the select tree, interface and top.
package mux_8x1_pkg;

    localparam int DEF_WIDTH = 1;

    localparam logic [2:0] SEL_A = 3'd0;
    localparam logic [2:0] SEL_B = 3'd1;
    localparam logic [2:0] SEL_C = 3'd2;
    localparam logic [2:0] SEL_D = 3'd3;
    localparam logic [2:0] SEL_E = 3'd4;
    localparam logic [2:0] SEL_F = 3'd5;
    localparam logic [2:0] SEL_G = 3'd6;
    localparam logic [2:0] SEL_H = 3'd7;

    function automatic logic [2:0] sel_code(
        input logic s2,
        input logic s1,
        input logic s0
    );
        return {s2, s1, s0};
    endfunction

endpackage

// File: rtl/mux_8x1_if.sv
// mux_8x1 signal bundle: eight data inputs, select bits, enable, output.
// master drives data/select/enable; slave returns the registered output.
interface mux_8x1_if
    import mux_8x1_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] e;
    logic [WIDTH-1:0] f;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] h;
    logic             sel0;
    logic             sel1;
    logic             sel2;
    logic             en;
    logic [WIDTH-1:0] o;

    modport master (
        output a, b, c, d, e, f, g, h,
        output sel0, sel1, sel2, en,
        input  o
    );

    modport slave (
        input  a, b, c, d, e, f, g, h,
        input  sel0, sel1, sel2, en,
        output o
    );
endinterface

// File: rtl/mux_8x1_mux_2x1.sv
// mux_2x1: combinational 2:1 leaf of the select tree.
// Ports: d0/d1 data, sel chooses d1 when high, y result.
module mux_2x1 #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);
    assign y = sel ? d1 : d0;
endmodule

// File: rtl/mux_8x1.sv
// mux_8x1: 8:1 select tree of mux_2x1 cells feeding one output register.
// Ports: A..H data, Sel0..Sel2 select (Sel2 MSB), O registered, clk, rst_n, en.
module mux_8x1
    import mux_8x1_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] E,
    input  logic [WIDTH-1:0] F,
    input  logic [WIDTH-1:0] G,
    input  logic [WIDTH-1:0] H,
    input  logic             Sel0,
    input  logic             Sel1,
    input  logic             Sel2,
    output logic [WIDTH-1:0] O,
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en
);
    logic [WIDTH-1:0] din [8];
    logic [WIDTH-1:0] lv1 [4];
    logic [WIDTH-1:0] lv2 [2];
    logic [WIDTH-1:0] sel_y;

    assign din[0] = A;
    assign din[1] = B;
    assign din[2] = C;
    assign din[3] = D;
    assign din[4] = E;
    assign din[5] = F;
    assign din[6] = G;
    assign din[7] = H;

    // Sel0 pairs neighbours, Sel1 picks a pair, Sel2 picks a half.
    for (genvar i = 0; i < 4; i++) begin : g_l1
        mux_2x1 #(.WIDTH(WIDTH)) u_mux (
            .d0  (din[2*i]),
            .d1  (din[2*i+1]),
            .sel (Sel0),
            .y   (lv1[i])
        );
    end

    for (genvar j = 0; j < 2; j++) begin : g_l2
        mux_2x1 #(.WIDTH(WIDTH)) u_mux (
            .d0  (lv1[2*j]),
            .d1  (lv1[2*j+1]),
            .sel (Sel1),
            .y   (lv2[j])
        );
    end

    mux_2x1 #(.WIDTH(WIDTH)) u_l3 (
        .d0  (lv2[0]),
        .d1  (lv2[1]),
        .sel (Sel2),
        .y   (sel_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            O <= '0;
        end else if (en) begin
            O <= sel_y;
        end
    end
endmodule

// File: tb/tb_mux_8x1.sv
// tb_mux_8x1: scoreboard bench for mux_8x1 at WIDTH=1 and WIDTH=8.
// Expected outputs are queued at drive time and compared after the edge.
module tb_mux_8x1;
    import mux_8x1_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] q1 [$];
    logic [7:0] q8 [$];
    logic [7:0] m1;
    logic [7:0] m8;

    mux_8x1_if #(.WIDTH(1)) n1 ();
    mux_8x1_if #(.WIDTH(8)) n8 ();

    always #10 clk = ~clk;

    mux_8x1 #(.WIDTH(1)) u_dut1 (
        .A(n1.a), .B(n1.b), .C(n1.c), .D(n1.d),
        .E(n1.e), .F(n1.f), .G(n1.g), .H(n1.h),
        .Sel0(n1.sel0), .Sel1(n1.sel1), .Sel2(n1.sel2),
        .O(n1.o), .clk(clk), .rst_n(rst_n), .en(n1.en)
    );

    mux_8x1 #(.WIDTH(8)) u_dut8 (
        .A(n8.a), .B(n8.b), .C(n8.c), .D(n8.d),
        .E(n8.e), .F(n8.f), .G(n8.g), .H(n8.h),
        .Sel0(n8.sel0), .Sel1(n8.sel1), .Sel2(n8.sel2),
        .O(n8.o), .clk(clk), .rst_n(rst_n), .en(n8.en)
    );

    task automatic check(
        input string      tag,
        input logic [7:0] got,
        input logic [7:0] exp
    );
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pick1(input logic [2:0] s);
        logic [0:0] r;
        case (s)
            SEL_A:   r = n1.a;
            SEL_B:   r = n1.b;
            SEL_C:   r = n1.c;
            SEL_D:   r = n1.d;
            SEL_E:   r = n1.e;
            SEL_F:   r = n1.f;
            SEL_G:   r = n1.g;
            default: r = n1.h;
        endcase
        return {7'b0, r};
    endfunction

    function automatic logic [7:0] pick8(input logic [2:0] s);
        case (s)
            SEL_A:   return n8.a;
            SEL_B:   return n8.b;
            SEL_C:   return n8.c;
            SEL_D:   return n8.d;
            SEL_E:   return n8.e;
            SEL_F:   return n8.f;
            SEL_G:   return n8.g;
            default: return n8.h;
        endcase
    endfunction

    task automatic cycle(
        input string      tag,
        input logic [2:0] s,
        input logic       e
    );
        @(negedge clk);
        {n1.sel2, n1.sel1, n1.sel0} = s;
        {n8.sel2, n8.sel1, n8.sel0} = s;
        n1.en = e;
        n8.en = e;
        if (e) begin
            m1 = pick1(s);
            m8 = pick8(s);
        end
        q1.push_back(m1);
        q8.push_back(m8);
        @(posedge clk);
        #1;
        check({tag, "_w1"}, {7'b0, n1.o}, q1.pop_front());
        check({tag, "_w8"}, n8.o, q8.pop_front());
    endtask

    task automatic load_pattern();
        {n1.a, n1.b, n1.c, n1.d} = 4'b0101;
        {n1.e, n1.f, n1.g, n1.h} = 4'b0101;
        n8.a = 8'h00; n8.b = 8'h11; n8.c = 8'h22; n8.d = 8'h33;
        n8.e = 8'h44; n8.f = 8'h55; n8.g = 8'h66; n8.h = 8'h77;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] wrap;
        n1.en = 1'b0;
        n8.en = 1'b0;
        {n1.sel2, n1.sel1, n1.sel0} = 3'd0;
        {n8.sel2, n8.sel1, n8.sel0} = 3'd0;
        load_pattern();

        #2 rst_n = 1'b0;
        #1;
        check("rst_w1", {7'b0, n1.o}, 8'h00);
        check("rst_w8", n8.o, 8'h00);
        m1 = 8'h00;
        m8 = 8'h00;
        n1.en = 1'b1;
        n8.en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_en_w1", {7'b0, n1.o}, 8'h00);
        check("rst_en_w8", n8.o, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        for (int s = 0; s < 8; s++) begin
            cycle("sweep", s[2:0], 1'b1);
        end
        check("sweep_h8", n8.o, 8'h77);

        for (int k = 0; k < 6; k++) begin
            n1.f = 1'b1;
            {n1.a, n1.b, n1.c, n1.d} = (k % 2 == 0) ? 4'hf : 4'h0;
            {n1.e, n1.g, n1.h} = (k % 2 == 0) ? 3'b111 : 3'b000;
            n8.a = 8'($urandom); n8.b = 8'($urandom);
            n8.c = 8'($urandom); n8.d = 8'($urandom);
            n8.e = 8'($urandom); n8.g = 8'($urandom);
            n8.h = 8'($urandom);
            cycle("iso", SEL_F, 1'b1);
        end
        check("iso_w1", {7'b0, n1.o}, 8'h01);
        check("iso_w8", n8.o, 8'h55);

        load_pattern();
        cycle("hold_ld", SEL_B, 1'b1);
        n1.a = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycle("hold", SEL_A, 1'b0);
        end
        check("hold_w1", {7'b0, n1.o}, 8'h01);
        cycle("hold_rel", SEL_A, 1'b1);

        cycle("ar_ld", SEL_B, 1'b1);
        @(negedge clk);
        #5 rst_n = 1'b0;
        #1;
        check("ar_now_w1", {7'b0, n1.o}, 8'h00);
        check("ar_now_w8", n8.o, 8'h00);
        m1 = 8'h00;
        m8 = 8'h00;
        @(posedge clk);
        #1;
        check("ar_hold_w1", {7'b0, n1.o}, 8'h00);
        check("ar_hold_w8", n8.o, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        cycle("ar_first", SEL_D, 1'b1);

        wrap = 4'd8;
        n1.a = 1'b0;
        n8.a = 8'ha5;
        cycle("wrap", wrap[2:0], 1'b1);
        check("wrap_a8", n8.o, 8'ha5);

        cycle("tail", SEL_G, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
